// File: rtl/mbscore_rf_gen2_if.sv
// Register-file bus for mbscore_rf_gen2: read, write, SPR and interrupt signals.
// The master drives addresses and write data. The slave returns read data and interrupt status.
interface mbscore_rf_gen2_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_GPR = 32,
    parameter int NUM_SPR = 8
);
    localparam int GA = $clog2(NUM_GPR);
    localparam int SA = $clog2(NUM_SPR);

    logic [GA-1:0]     rs_addr, rt_addr, alu_addr, mem_addr;
    logic [SA-1:0]     spr_rd_addr, spr_wr_addr;
    logic              alu_we, lui, link_we, mem_we, spr_we, intr_req, eret;
    logic [DATA_W-1:0] alu_data, pc_in, mem_data, spr_wdata, spr_mask;
    logic [DATA_W-1:0] rs_data, rt_data, spr_data, epc;
    logic              int_dis, intr_ack;

    modport master (
        output rs_addr, rt_addr, spr_rd_addr, alu_we, alu_addr, alu_data, lui, link_we,
               pc_in, mem_we, mem_addr, mem_data, spr_we, spr_wr_addr, spr_wdata,
               spr_mask, intr_req, eret,
        input  rs_data, rt_data, spr_data, epc, int_dis, intr_ack
    );
    modport slave (
        input  rs_addr, rt_addr, spr_rd_addr, alu_we, alu_addr, alu_data, lui, link_we,
               pc_in, mem_we, mem_addr, mem_data, spr_we, spr_wr_addr, spr_wdata,
               spr_mask, intr_req, eret,
        output rs_data, rt_data, spr_data, epc, int_dis, intr_ack
    );
endinterface

// File: rtl/mbscore_rf_gen2.sv
// MBScore gen2 register file: a GPR bank with two read ports and ALU/memory writes, plus an SPR bank
// that holds hardware interrupt entry and ERET state.
module mbscore_rf_gen2 #(
    parameter int DATA_W   = 32,
    parameter int NUM_GPR  = 32,
    parameter int NUM_SPR  = 8,
    parameter int LINK_REG = 31,
    parameter int PC_INC   = 4,
    parameter int EPC_IDX  = 0,
    parameter int STAT_IDX = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mbscore_rf_gen2_if.slave     bus
);
    localparam int GA = $clog2(NUM_GPR);
    localparam int SA = $clog2(NUM_SPR);
    localparam logic [GA-1:0] LINK_A = GA'(LINK_REG);
    localparam logic [SA-1:0] EPC_A  = SA'(EPC_IDX);
    localparam logic [SA-1:0] STAT_A = SA'(STAT_IDX);

    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic [DATA_W-1:0] gpr_d [NUM_GPR];
    logic [DATA_W-1:0] spr_q [NUM_SPR];
    logic [DATA_W-1:0] spr_d [NUM_SPR];
    logic [GA-1:0]     rs_q, rs_d, rt_q, rt_d;
    logic [SA-1:0]     spr_rd_q, spr_rd_d;
    logic              intr_ack_q, intr_ack_d;

    logic              alu_wr, take;
    logic [GA-1:0]     alu_wa;
    logic [DATA_W-1:0] alu_wd;

    always_comb begin
        rs_d     = bus.rs_addr;
        rt_d     = bus.rt_addr;
        spr_rd_d = bus.spr_rd_addr;

        alu_wr = bus.link_we | bus.alu_we;
        alu_wa = bus.link_we ? LINK_A : bus.alu_addr;
        if (bus.link_we)  alu_wd = bus.pc_in + DATA_W'(PC_INC);
        else if (bus.lui) alu_wd = bus.alu_data << (DATA_W/2);
        else              alu_wd = bus.alu_data;

        // The memory write is applied last, so it wins a same-address collision with the ALU write.
        gpr_d = gpr_q;
        if (alu_wr)     gpr_d[alu_wa] = alu_wd;
        if (bus.mem_we) gpr_d[bus.mem_addr] = bus.mem_data;
        gpr_d[0] = '0;

        // An ERET in the same cycle blocks interrupt entry.
        take       = bus.intr_req & ~spr_q[STAT_A][0] & ~bus.eret;
        intr_ack_d = take;

        // Hardware updates are applied after the masked write, so they win only on the bits they touch.
        spr_d = spr_q;
        if (bus.spr_we)
            spr_d[bus.spr_wr_addr] = (bus.spr_wdata & bus.spr_mask) |
                                     (spr_q[bus.spr_wr_addr] & ~bus.spr_mask);
        if (take) begin
            spr_d[EPC_A]     = bus.pc_in;
            spr_d[STAT_A][0] = 1'b1;
        end
        if (bus.eret) spr_d[STAT_A][0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
            for (int i = 0; i < NUM_SPR; i++) spr_q[i] <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            spr_rd_q   <= '0;
            intr_ack_q <= 1'b0;
        end else begin
            gpr_q      <= gpr_d;
            spr_q      <= spr_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            spr_rd_q   <= spr_rd_d;
            intr_ack_q <= intr_ack_d;
        end
    end

    // Reads come from the next-state arrays, so a pending write is bypassed to the outputs.
    assign bus.rs_data  = (rs_q == '0) ? '0 : gpr_d[rs_q];
    assign bus.rt_data  = (rt_q == '0) ? '0 : gpr_d[rt_q];
    assign bus.spr_data = spr_d[spr_rd_q];
    assign bus.epc      = spr_q[EPC_A];
    assign bus.int_dis  = spr_q[STAT_A][0];
    assign bus.intr_ack = intr_ack_q;
endmodule

// File: tb/tb_mbscore_rf_gen2.sv
// Directed-vector bench for mbscore_rf_gen2. The expected values were worked out by hand.
module tb_mbscore_rf_gen2;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mbscore_rf_gen2_if #(.DATA_W(32), .NUM_GPR(32), .NUM_SPR(8)) bus ();
    mbscore_rf_gen2 dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_we = 0; bus.lui = 0; bus.link_we = 0; bus.mem_we = 0;
        bus.spr_we = 0; bus.intr_req = 0; bus.eret = 0;
        bus.alu_addr = 0; bus.alu_data = 0; bus.mem_addr = 0; bus.mem_data = 0;
        bus.spr_wr_addr = 0; bus.spr_wdata = 0; bus.spr_mask = 0; bus.pc_in = 0;
    endtask

    initial begin
        idle();
        bus.rs_addr = 0; bus.rt_addr = 0; bus.spr_rd_addr = 0;
        rst = 1;
        tick(); tick();
        // A write attempted under reset must be dropped.
        bus.alu_we = 1; bus.alu_addr = 5; bus.alu_data = 32'hDEADBEEF;
        tick();
        rst = 0; idle();
        check("rst_int_dis", {31'd0, bus.int_dis}, 0);
        check("rst_ack", {31'd0, bus.intr_ack}, 0);
        check("rst_epc", bus.epc, 0);
        for (int i = 0; i < 32; i++) begin
            bus.rs_addr = 5'(i); bus.rt_addr = 5'(31 - i); bus.spr_rd_addr = 3'(i);
            tick(); #1;
            check($sformatf("rst_rs%0d", i), bus.rs_data, 0);
            check($sformatf("rst_rt%0d", i), bus.rt_data, 0);
            if (i < 8) check($sformatf("rst_spr%0d", i), bus.spr_data, 0);
        end

        // Plain ALU write, then a read on the next cycle.
        bus.alu_we = 1; bus.alu_addr = 5; bus.alu_data = 32'h12345678; bus.rs_addr = 5;
        tick(); idle(); #1;
        check("alu_wr5", bus.rs_data, 32'h12345678);

        // The incoming write is visible in the same cycle through the bypass.
        bus.rs_addr = 9; tick();
        bus.alu_we = 1; bus.alu_addr = 9; bus.alu_data = 32'h0000CAFE; #1;
        check("alu_byp9", bus.rs_data, 32'h0000CAFE);
        tick(); idle(); #1;
        check("alu_wr9", bus.rs_data, 32'h0000CAFE);

        bus.alu_we = 1; bus.lui = 1; bus.alu_addr = 6; bus.alu_data = 32'h0000ABCD; bus.rt_addr = 6;
        tick(); idle(); #1;
        check("lui", bus.rt_data, 32'hABCD0000);

        // Register 0 reads as zero even while a write to it is pending.
        bus.rs_addr = 0; bus.alu_we = 1; bus.alu_addr = 0; bus.alu_data = 32'hFFFFFFFF;
        tick(); #1;
        check("gpr0_byp", bus.rs_data, 0);
        idle(); tick(); #1;
        check("gpr0", bus.rs_data, 0);

        // ALU and memory write the same address in one cycle: the memory write wins.
        bus.rs_addr = 7; tick();
        bus.alu_we = 1; bus.alu_addr = 7; bus.alu_data = 32'h11;
        bus.mem_we = 1; bus.mem_addr = 7; bus.mem_data = 32'h22; #1;
        check("coll_byp", bus.rs_data, 32'h22);
        tick(); idle(); #1;
        check("coll", bus.rs_data, 32'h22);

        bus.alu_we = 1; bus.alu_addr = 10; bus.alu_data = 32'hA;
        bus.mem_we = 1; bus.mem_addr = 11; bus.mem_data = 32'hB;
        bus.rs_addr = 10; bus.rt_addr = 11;
        tick(); idle(); #1;
        check("dual_alu", bus.rs_data, 32'hA);
        check("dual_mem", bus.rt_data, 32'hB);

        // A link write targets register 31 and ignores alu_addr and lui.
        bus.link_we = 1; bus.alu_we = 1; bus.lui = 1; bus.alu_addr = 3; bus.alu_data = 32'h55;
        bus.pc_in = 32'h100; bus.rs_addr = 31; bus.rt_addr = 3;
        tick(); idle(); #1;
        check("link31", bus.rs_data, 32'h104);
        check("link_gpr3", bus.rt_data, 0);
        bus.link_we = 1; bus.pc_in = 32'hFFFFFFFE;
        tick(); idle(); #1;
        check("link_wrap", bus.rs_data, 32'h2);

        // Masked SPR write, including the bypassed value.
        bus.spr_we = 1; bus.spr_wr_addr = 2; bus.spr_wdata = 32'hFFFF0000; bus.spr_mask = 32'hFFFFFFFF;
        bus.spr_rd_addr = 2;
        tick();
        bus.spr_wdata = 32'h00001234; bus.spr_mask = 32'h0000FFFF; #1;
        check("spr_byp", bus.spr_data, 32'hFFFF1234);
        tick(); idle(); #1;
        check("spr_mask", bus.spr_data, 32'hFFFF1234);

        // Interrupt entry, then a request that is ignored while interrupts are disabled.
        bus.pc_in = 32'h400; bus.intr_req = 1;
        tick(); #1;
        check("int_epc", bus.epc, 32'h400);
        check("int_dis", {31'd0, bus.int_dis}, 1);
        check("int_ack", {31'd0, bus.intr_ack}, 1);
        bus.pc_in = 32'h500;
        tick(); #1;
        check("int2_ack", {31'd0, bus.intr_ack}, 0);
        check("int2_epc", bus.epc, 32'h400);
        bus.eret = 1;
        tick(); bus.eret = 0; #1;
        check("eret_dis", {31'd0, bus.int_dis}, 0);
        check("eret_ack", {31'd0, bus.intr_ack}, 0);
        check("eret_epc", bus.epc, 32'h400);
        tick(); #1;
        check("reent_ack", {31'd0, bus.intr_ack}, 1);
        check("reent_dis", {31'd0, bus.int_dis}, 1);
        check("reent_epc", bus.epc, 32'h500);
        bus.intr_req = 0;
        tick(); #1;
        check("ack_pulse", {31'd0, bus.intr_ack}, 0);

        // ERET overrides STAT bit0 only; bit1 still takes the masked write.
        bus.eret = 1; bus.spr_we = 1; bus.spr_wr_addr = 1; bus.spr_wdata = 32'h3; bus.spr_mask = 32'h3;
        bus.spr_rd_addr = 1;
        tick(); idle(); #1;
        check("stat_mix", bus.spr_data, 32'h2);
        check("stat_dis", {31'd0, bus.int_dis}, 0);

        // Interrupt entry overrides a same-cycle SPR write to EPC.
        bus.intr_req = 1; bus.pc_in = 32'h600;
        bus.spr_we = 1; bus.spr_wr_addr = 0; bus.spr_wdata = 32'hDEAD; bus.spr_mask = 32'hFFFFFFFF;
        tick(); idle(); #1;
        check("epc_ovr", bus.epc, 32'h600);
        check("epc_ack", {31'd0, bus.intr_ack}, 1);

        // Reset in the middle of an interrupt clears the interrupt state.
        rst = 1;
        tick(); rst = 0; #1;
        check("mid_rst_epc", bus.epc, 0);
        check("mid_rst_dis", {31'd0, bus.int_dis}, 0);
        check("mid_rst_ack", {31'd0, bus.intr_ack}, 0);
        check("mid_rst_stat", bus.spr_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
